// File: rtl/adc_chan_sequencer_32ch_pkg.sv
// adc_seq_pkg: shared widths and state encoding for the ADC channel sequencer
package adc_seq_pkg;
  localparam int NUM_CH_DEF = 32;
  localparam int SEL_W = 5;
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} seq_state_t;
endpackage

// File: rtl/adc_chan_sequencer_32ch_next_ch_find.sv
// adc_next_ch_find: next enabled channel above the current one, plus the lowest enabled channel
module adc_next_ch_find
  import adc_seq_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  localparam int SW = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] i_mask,
  input  logic [SW-1:0]     i_cur,
  output logic [SW-1:0]     o_nxt,
  output logic              o_found,
  output logic [SW-1:0]     o_lowest
);
  // descending scan so the last hit is the lowest qualifying index
  always_comb begin
    o_nxt = '0;
    o_found = 1'b0;
    o_lowest = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (i_mask[i]) o_lowest = SW'(i);
      if (i_mask[i] && SW'(i) > i_cur) begin
        o_found = 1'b1;
        o_nxt = SW'(i);
      end
    end
  end
endmodule

// File: rtl/adc_chan_sequencer_32ch.sv
// adc_chan_sequencer_32ch: walks enabled mux channels with a dwell, tags samples at mux output; ADC_SEQ_FRAME_CNT_EN adds frame_cnt
module adc_chan_sequencer_32ch
  import adc_seq_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int DWELL = 1,
  parameter int MUX_LAT = 1,
  localparam int SW = $clog2(NUM_CH),
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1
) (
  input  logic              clk,
  input  logic              GlobalReset,
  input  logic              start,
  input  logic              stop,
  input  logic              continuous,
  input  logic [NUM_CH-1:0] chan_en_mask,
  output logic [SW-1:0]     x_adc_select,
  output logic              x_adc_valid,
  output logic [SW-1:0]     x_adc_ch,
  output logic              frame_done,
  output logic              busy
`ifdef ADC_SEQ_FRAME_CNT_EN
  ,
  output logic [15:0]       frame_cnt
`endif
);
  seq_state_t r_state;
  logic [SW-1:0] r_sel;
  logic [NUM_CH-1:0] r_mask;
  logic r_cont, r_busy, r_empty_fd;
  logic [CW-1:0] r_cnt;
  logic [MUX_LAT-1:0] r_vld, r_lst;
  logic [MUX_LAT-1:0][SW-1:0] r_tag;
  logic [SW-1:0] w_adv_nxt, w_new_lo, w_unused_adv_lo, w_unused_new_nxt;
  logic w_adv_found, w_unused_new_found, w_strobe, w_inflight;

  adc_next_ch_find #(.NUM_CH(NUM_CH)) u_adv (
    .i_mask(r_mask), .i_cur(r_sel),
    .o_nxt(w_adv_nxt), .o_found(w_adv_found), .o_lowest(w_unused_adv_lo)
  );

  adc_next_ch_find #(.NUM_CH(NUM_CH)) u_new (
    .i_mask(chan_en_mask), .i_cur('0),
    .o_nxt(w_unused_new_nxt), .o_found(w_unused_new_found), .o_lowest(w_new_lo)
  );

  assign w_strobe = (r_state == SCAN) && (r_cnt == CW'(DWELL - 1));
  assign w_inflight = |(r_vld & MUX_LAT'((1 << (MUX_LAT - 1)) - 1));
  assign x_adc_select = r_sel;
  assign x_adc_valid = r_vld[MUX_LAT-1];
  assign x_adc_ch = r_tag[MUX_LAT-1];
  assign frame_done = (r_vld[MUX_LAT-1] & r_lst[MUX_LAT-1]) | r_empty_fd;
  assign busy = r_busy;

  // sequencing FSM plus the strobe/tag/last delay line that tracks mux latency
  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      r_state <= IDLE;
      r_sel <= '0;
      r_mask <= '0;
      r_cont <= 1'b0;
      r_busy <= 1'b0;
      r_empty_fd <= 1'b0;
      r_cnt <= '0;
      r_vld <= '0;
      r_lst <= '0;
      r_tag <= '0;
    end else if (stop) begin
      r_state <= IDLE;
      r_sel <= '0;
      r_busy <= 1'b0;
      r_empty_fd <= 1'b0;
      r_cnt <= '0;
      r_vld <= '0;
      r_lst <= '0;
    end else begin
      r_vld <= MUX_LAT'({r_vld, w_strobe});
      r_lst <= MUX_LAT'({r_lst, w_strobe & ~w_adv_found});
      r_tag <= (MUX_LAT * SW)'({r_tag, r_sel});
      r_empty_fd <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mask <= chan_en_mask;
            r_cont <= continuous;
            if (|chan_en_mask) begin
              r_busy <= 1'b1;
              r_state <= SCAN;
              r_sel <= w_new_lo;
              r_cnt <= '0;
            end else begin
              r_empty_fd <= 1'b1;
            end
          end
        end
        SCAN: begin
          r_cnt <= w_strobe ? '0 : r_cnt + 1'b1;
          if (w_strobe) begin
            if (w_adv_found) begin
              r_sel <= w_adv_nxt;
            end else if (r_cont) begin
              r_mask <= chan_en_mask;
              r_sel <= w_new_lo;
              if (~|chan_en_mask) r_state <= DRAIN;
            end else begin
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (!w_inflight) begin
            r_state <= IDLE;
            r_busy <= 1'b0;
            r_sel <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ADC_SEQ_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;
  assign frame_cnt = r_frame_cnt;

  // frames completed since the last accepted start, wrapping at 16 bits
  always_ff @(posedge clk) begin
    if (GlobalReset) r_frame_cnt <= '0;
    else if (start && !stop && r_state == IDLE) r_frame_cnt <= '0;
    else if (frame_done) r_frame_cnt <= r_frame_cnt + 16'd1;
  end
`endif
endmodule
